// File: rtl/clk_en_nco_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : clk_en_pkg                                                    |
// | Description: Shared types and helpers for the NCO clock-enable bank:       |
// |              lock FSM state type and a constant function that turns a      |
// |              clock/enable frequency pair into an accumulator increment.    |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package clk_en_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } lock_state_t;

   // Nearest-integer increment giving f_ce_hz enables from f_clk_hz with an
   // acc_w-bit accumulator: round(f_ce * 2^acc_w / f_clk).
   function automatic longint unsigned inc_for(input longint unsigned f_clk_hz,
                                               input longint unsigned f_ce_hz,
                                               input int unsigned     acc_w);
      longint unsigned num;
      num = (f_ce_hz << acc_w) + (f_clk_hz >> 1);
      return num / f_clk_hz;
   endfunction

   // Example rates: CoCo E clock (14.31818 MHz / 16) from a 50 MHz master.
   localparam longint unsigned INC_COCO_E_50M  = inc_for(64'd50_000_000, 64'd894_886, 24);
   localparam longint unsigned INC_COCO_Q_50M  = inc_for(64'd50_000_000, 64'd3_579_545, 24);

endpackage
`default_nettype wire

// File: rtl/clk_en_nco_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : clk_en_nco_bank_if                                            |
// | Description: Control/status bundle of the NCO clock-enable bank.           |
// |   inc_i   : per-channel increment, ch n at [n*ACC_W +: ACC_W]              |
// |   ch_en_i : per-channel run enable                                         |
// |   sync_i  : phase-align pulse, clears all accumulators                     |
// |   ready_o : high while the bank is running                                 |
// |   ce_o    : registered single-cycle clock enables                          |
// |   master  : drives controls, observes status (system side)                 |
// |   slave   : the bank itself                                                |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface clk_en_nco_bank_if #(
   parameter int NUM_CH = 4,
   parameter int ACC_W  = 24
);
   logic [NUM_CH*ACC_W-1:0] inc_i;
   logic [NUM_CH-1:0]       ch_en_i;
   logic                    sync_i;
   logic                    ready_o;
   logic [NUM_CH-1:0]       ce_o;

   modport master (
      output inc_i, ch_en_i, sync_i,
      input  ready_o, ce_o
   );

   modport slave (
      input  inc_i, ch_en_i, sync_i,
      output ready_o, ce_o
   );
endinterface
`default_nettype wire

// File: rtl/clk_en_nco_bank_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : clk_en_nco_ch                                                 |
// | Description: One NCO channel: accumulator, shadowed increment and a        |
// |              registered carry that forms the clock enable.                 |
// |   clk, rst_n : master clock, async active-low reset                        |
// |   run_i      : bank is in RUN with lock still present                      |
// |   first_i    : first RUN cycle (load shadow)                               |
// |   sync_i     : phase-align request                                         |
// |   en_i       : channel enable                                              |
// |   inc_i      : increment for this channel                                  |
// |   ce_o       : registered single-cycle enable                              |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module clk_en_nco_ch #(
   parameter int ACC_W = 24
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             run_i,
   input  wire logic             first_i,
   input  wire logic             sync_i,
   input  wire logic             en_i,
   input  wire logic [ACC_W-1:0] inc_i,
   output logic                  ce_o
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] shadow_q;
   logic             ce_q;
   logic [ACC_W:0]   sum;

   assign sum  = {1'b0, acc_q} + {1'b0, shadow_q};
   assign ce_o = ce_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         shadow_q <= '0;
         ce_q     <= 1'b0;
      end else if (!run_i) begin
         acc_q    <= '0;
         shadow_q <= '0;
         ce_q     <= 1'b0;
      end else if (sync_i || !en_i) begin
         // Phase-align or idle channel: park at zero phase with the live
         // increment so the next period starts cleanly.
         acc_q    <= '0;
         shadow_q <= inc_i;
         ce_q     <= 1'b0;
      end else begin
         acc_q <= sum[ACC_W-1:0];
         ce_q  <= sum[ACC_W];
         // Increment only switches at a wrap so no period is ever truncated.
         if (sum[ACC_W] || first_i) begin
            shadow_q <= inc_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/clk_en_nco_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : clk_en_nco_bank                                               |
// | Description: Multi-channel fractional clock-enable generator. Each channel |
// |              fires at f_clk*inc/2^ACC_W. All enables are held off until    |
// |              the synchronised PLL lock has been stable for LOCK_CYCLES.    |
// |   clk        : master clock (PLL output)                                   |
// |   rst_n      : asynchronous active-low reset                               |
// |   pll_locked : PLL lock, asynchronous to clk                               |
// |   bus        : control/status bundle (slave side)                          |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module clk_en_nco_bank
   import clk_en_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int ACC_W       = 24,
   parameter int LOCK_CYCLES = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          pll_locked,
   clk_en_nco_bank_if.slave   bus
);

   localparam int               CNT_W    = $clog2(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   logic [SYNC_STAGES-1:0] lk_sync_q;
   logic                   lk;
   lock_state_t            state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ready_q;
   logic                   first_q;
   logic                   run;
   logic [NUM_CH-1:0]      ce_w;

   // Lock synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_sync_q <= '0;
      end else begin
         lk_sync_q <= {lk_sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign lk = lk_sync_q[SYNC_STAGES-1];

   // Lock qualification FSM with registered ready and first-RUN-cycle flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         first_q <= 1'b0;
      end else begin
         first_q <= 1'b0;
         case (state_q)
            WAIT_LOCK: begin
               cnt_q <= '0;
               if (lk) begin
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (!lk) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
                  first_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (!lk) begin
                  state_q <= WAIT_LOCK;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= WAIT_LOCK;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Gating on the live lock makes a lock loss win over carry and sync in
   // the very cycle it is seen.
   assign run = (state_q == RUN) && lk;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      clk_en_nco_ch #(
         .ACC_W (ACC_W)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .run_i   (run),
         .first_i (first_q),
         .sync_i  (bus.sync_i),
         .en_i    (bus.ch_en_i[n]),
         .inc_i   (bus.inc_i[n*ACC_W +: ACC_W]),
         .ce_o    (ce_w[n])
      );
   end

   assign bus.ce_o    = ce_w;
   assign bus.ready_o = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_en_nco_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_clk_en_nco_bank                                            |
// | Description: Self-checking bench for clk_en_nco_bank against a lock        |
// |              streak / phase arithmetic reference model.                    |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_clk_en_nco_bank;

   localparam int NUM_CH      = 4;
   localparam int ACC_W       = 4;
   localparam int LOCK_CYCLES = 8;
   localparam int SYNC_STAGES = 2;
   localparam int MOD         = 1 << ACC_W;

   logic clk;
   logic rst_n;
   logic pll_locked;

   clk_en_nco_bank_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

   clk_en_nco_bank #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Stimulus state
   logic              pl;
   int                inc_v [NUM_CH];
   logic [NUM_CH-1:0] en_v;
   logic              sync_v;

   // Reference model state
   int m_phase  [NUM_CH];
   int m_shadow [NUM_CH];
   bit m_ce     [NUM_CH];
   bit m_ready;
   int m_streak;
   bit m_hist   [SYNC_STAGES];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < NUM_CH; n++) begin
         m_phase[n] = 0; m_shadow[n] = 0; m_ce[n] = 0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) m_hist[s] = 0;
      m_ready  = 0;
      m_streak = 0;
   endtask

   // Ready is high once synchronised lock has been seen on LOCK_CYCLES+1
   // consecutive edges (one edge to leave WAIT_LOCK, LOCK_CYCLES to settle).
   task automatic model_step();
      bit lk, run, first;
      int total;
      lk = m_hist[SYNC_STAGES-1];
      for (int s = SYNC_STAGES-1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = pl;
      run   = m_ready && lk;
      first = run && (m_streak == LOCK_CYCLES + 1);
      if (lk) begin
         if (m_streak < 1000000) m_streak++;
      end else begin
         m_streak = 0;
      end
      m_ready = (m_streak >= LOCK_CYCLES + 1);
      for (int n = 0; n < NUM_CH; n++) begin
         if (!run) begin
            m_phase[n] = 0; m_shadow[n] = 0; m_ce[n] = 0;
         end else if (sync_v || !en_v[n]) begin
            m_phase[n] = 0; m_shadow[n] = inc_v[n]; m_ce[n] = 0;
         end else begin
            total      = m_phase[n] + m_shadow[n];
            m_ce[n]    = (total / MOD) != 0;
            m_phase[n] = total % MOD;
            if (m_ce[n] || first) m_shadow[n] = inc_v[n];
         end
      end
   endtask

   task automatic drive();
      pll_locked = pl;
      for (int n = 0; n < NUM_CH; n++) bus.inc_i[n*ACC_W +: ACC_W] = ACC_W'(inc_v[n]);
      bus.ch_en_i = en_v;
      bus.sync_i  = sync_v;
   endtask

   task automatic check_all();
      check_val("ready", {31'd0, bus.ready_o}, {31'd0, m_ready});
      for (int n = 0; n < NUM_CH; n++)
         check_val($sformatf("ce%0d", n), {31'd0, bus.ce_o[n]}, {31'd0, m_ce[n]});
   endtask

   // Called right after a falling edge: apply inputs, predict, check next fall.
   task automatic cycle();
      drive();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_ready", {31'd0, bus.ready_o}, 32'd0);
      check_val("async_rst_ce", {28'd0, bus.ce_o}, 32'd0);
      model_reset();
      pl = 1'b0; sync_v = 1'b0;
      drive();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int cnt, last, gmin, gmax, first0, first1, drop_cnt;

   initial begin
      rst_n = 1'b0; pl = 1'b0; sync_v = 1'b0; en_v = '1;
      for (int n = 0; n < NUM_CH; n++) inc_v[n] = 0;
      drive();
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_ready", {31'd0, bus.ready_o}, 32'd0);
      check_val("rst_ce", {28'd0, bus.ce_o}, 32'd0);
      rst_n = 1'b1;

      // Lock latency: 2 sync + 1 + 8 settle edges.
      inc_v[0] = 4;
      pl = 1'b1;
      cnt = 0;
      do begin cycle(); cnt++; end while (!bus.ready_o && cnt < 40);
      check_val("t1_lock_latency", cnt, 11);

      // inc=4: four pulses per 16 cycles.
      repeat (4) cycle();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin cycle(); if (bus.ce_o[0]) cnt++; end
      check_val("t2_inc4_count", cnt, 4);

      // inc=3: three pulses per 16 cycles, gaps 5/5/6.
      inc_v[0] = 3;
      repeat (16) cycle();
      cnt = 0; last = -1; gmin = 1000; gmax = 0;
      for (int i = 0; i < 48; i++) begin
         cycle();
         if (bus.ce_o[0]) begin
            cnt++;
            if (last >= 0) begin
               if (i - last < gmin) gmin = i - last;
               if (i - last > gmax) gmax = i - last;
            end
            last = i;
         end
      end
      check_val("t2_inc3_count", cnt, 9);
      check_val("t2_inc3_gmin", gmin, 5);
      check_val("t2_inc3_gmax", gmax, 6);

      // inc 4 -> 8 mid-period: shortest gap must be the new 2-cycle period.
      inc_v[0] = 4;
      repeat (16) cycle();
      repeat (2) cycle();
      inc_v[0] = 8;
      last = -1; gmin = 1000;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (bus.ce_o[0]) begin
            if (last >= 0 && i - last < gmin) gmin = i - last;
            last = i;
         end
      end
      check_val("t3_min_gap", gmin, 2);

      // Lock glitch during SETTLE restarts qualification.
      do_reset();
      pl = 1'b1;
      repeat (5) cycle();
      pl = 1'b0;
      cycle();
      pl = 1'b1;
      cnt = 0;
      do begin cycle(); cnt++; end while (!bus.ready_o && cnt < 40);
      check_val("t4_settle_restart", cnt, 11);

      // Lock glitch during RUN: ready drops once the low reaches lk.
      repeat (3) cycle();
      cnt = 0;
      do begin
         pl = (cnt == 0) ? 1'b0 : 1'b1;
         cycle();
         cnt++;
      end while (bus.ready_o && cnt < 20);
      check_val("t4_run_drop", cnt, 3);
      cnt = 0;
      do begin cycle(); cnt++; end while (!bus.ready_o && cnt < 40);
      check_val("t4_relock", {31'd0, bus.ready_o}, 32'd1);

      // Drifting channels, then phase-align.
      inc_v[0] = 5; inc_v[1] = 7;
      repeat (30) cycle();
      sync_v = 1'b1;
      cycle();
      check_val("t5_sync_ce", {28'd0, bus.ce_o}, 32'd0);
      sync_v = 1'b0;
      first0 = 0; first1 = 0;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         if (bus.ce_o[0] && first0 == 0) first0 = i;
         if (bus.ce_o[1] && first1 == 0) first1 = i;
      end
      check_val("t5_first_ch0", first0, 4);
      check_val("t5_first_ch1", first1, 3);

      // inc=0 never fires; inc=15 fires 15 of 16.
      inc_v[0] = 0;
      sync_v = 1'b1; cycle(); sync_v = 1'b0;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin cycle(); if (bus.ce_o[0]) cnt++; end
      check_val("t6_inc0_count", cnt, 0);
      inc_v[0] = 15;
      sync_v = 1'b1; cycle(); sync_v = 1'b0;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin cycle(); if (bus.ce_o[0]) cnt++; end
      check_val("t6_inc15_count", cnt, 30);

      // Reset in the middle of RUN.
      do_reset();

      // Randomised traffic against the model.
      drop_cnt = 0;
      pl = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (drop_cnt > 0) begin
            pl = 1'b0; drop_cnt--;
         end else begin
            pl = 1'b1;
            if ($urandom_range(0, 299) == 0) drop_cnt = $urandom_range(1, 3);
         end
         for (int n = 0; n < NUM_CH; n++) begin
            if ($urandom_range(0, 39) == 0) inc_v[n] = $urandom_range(0, MOD - 1);
            if ($urandom_range(0, 59) == 0) en_v[n] = ~en_v[n];
         end
         sync_v = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
